switch_matrix_scanner: RTL

Input-side counterpart to the LED array driver. Scans an N×N switch/button matrix one column at a time, synchronizes and debounces every key, and produces a cell bitmap that uses the same N*row + col indexing as the game grid. The bitmap feeds the game's initial-state path, so players can draw patterns by hand.

---
 rtl/switch_matrix_scanner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/switch_matrix_scanner.sv
// Column-at-a-time N x N key matrix scanner with per-key synchronizing debounce and a game-grid bitmap.
// Define SWITCH_MATRIX_TOGGLE_EN to make each debounced press toggle its pattern cell instead of mirroring pressed.
module switch_matrix_scanner #(
  parameter int N              = 8,
  parameter int SETTLE_CYCLES  = 64,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N-1:0]     row_sense,
  output logic [N-1:0]     col_drive,
  output logic [N*N-1:0]   pressed,
  output logic [N*N-1:0]   press_pulse,
  output logic [N*N-1:0]   pattern,
  output logic             frame_done
);

  localparam int KW = $clog2(N);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [KW-1:0] K_LAST      = KW'(N - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LIMIT   = CW'(DEBOUNCE_SCANS);
  localparam logic [N-1:0]  COL_ONE     = N'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

  state_t        state, state_next;
  logic [KW-1:0] k, k_next;
  logic [SW-1:0] settle, settle_next;
  logic [N-1:0]  sync1, sync2;
  logic          sample_en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= row_sense;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      settle     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      k          <= k_next;
      settle     <= settle_next;
      frame_done <= (state == SAMPLE) && (k == K_LAST);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    k_next      = k;
    settle_next = settle;
    unique case (state)
      IDLE: begin
        if (ena) begin
          state_next  = DRIVE;
          k_next      = '0;
          settle_next = '0;
        end
      end
      DRIVE: begin
        if (settle == SETTLE_LAST) state_next = SAMPLE;
        else                       settle_next = settle + 1'b1;
      end
      SAMPLE: begin
        settle_next = '0;
        if (!ena) begin
          state_next = IDLE;
          k_next     = '0;
        end else begin
          state_next = DRIVE;
          k_next     = (k == K_LAST) ? '0 : k + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign col_drive = (state == IDLE) ? '0 : (COL_ONE << k);
  assign sample_en = (state == SAMPLE);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int IDX = r * N + c;
      logic [CW-1:0] cnt, cnt_inc;
      logic          key_q, pulse_q, hit, mismatch, flip;

      assign hit      = sample_en && (k == KW'(c));
      assign cnt_inc  = cnt + 1'b1;
      assign mismatch = (sync2[r] != key_q);
      assign flip     = hit && mismatch && (cnt_inc == DEB_LIMIT);

      // NOTE: debounce counters sit in the reset path too, so a scan after reset never inherits half-counted bounces.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt     <= '0;
          key_q   <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= flip && !key_q;
          if (hit) begin
            cnt <= (!mismatch || flip) ? '0 : cnt_inc;
            if (flip) key_q <= ~key_q;
          end
        end
      end

      assign pressed[IDX]     = key_q;
      assign press_pulse[IDX] = pulse_q;

`ifdef SWITCH_MATRIX_TOGGLE_EN
      logic pat_q;
      always_ff @(posedge clk) begin
        if (rst)                 pat_q <= 1'b0;
        else if (flip && !key_q) pat_q <= ~pat_q;
      end
      assign pattern[IDX] = pat_q;
`else
      assign pattern[IDX] = key_q;
`endif
    end
  end

endmodule
